// File: rtl/axi_pkg.sv
// -----------------------------------------------------------------------------
// axi_pkg
// Shared AXI definitions for the write-side (and later read-side) responders:
// burst/response encodings, responder FSM states, default bus widths and a
// couple of small helper functions used when building write responses.
// -----------------------------------------------------------------------------
package axi_pkg;

    localparam int AXI_ID_WIDTH   = 4;
    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2,
        BURST_RSVD  = 2'd3
    } burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'd0,
        RESP_EXOKAY = 2'd1,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } resp_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_RESP = 2'd2
    } wr_state_e;

    // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

    // Combine two error codes: DECERR dominates SLVERR, SLVERR dominates OKAY.
    function automatic resp_e resp_merge(input resp_e a, input resp_e b);
        if ((a == RESP_DECERR) || (b == RESP_DECERR)) begin
            return RESP_DECERR;
        end else if ((a == RESP_SLVERR) || (b == RESP_SLVERR)) begin
            return RESP_SLVERR;
        end else begin
            return RESP_OKAY;
        end
    endfunction

endpackage

// File: rtl/axi_wr_responder_if.sv
// -----------------------------------------------------------------------------
// axi_wr_responder_if
// AXI write channels (AW, W, B). The master modport is used by the driving
// agent, the slave modport by the responder.
//   AW: awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos,
//       awregion, awvalid (m->s), awready (s->m)
//   W : wid, wdata, wstrb, wlast, wvalid (m->s), wready (s->m)
//   B : bid, bresp, bvalid (s->m), bready (m->s)
// -----------------------------------------------------------------------------
interface axi_wr_responder_if #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ID_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic [1:0]            awlock;
    logic [3:0]            awcache;
    logic [2:0]            awprot;
    logic [3:0]            awqos;
    logic [3:0]            awregion;
    logic                  awvalid;
    logic                  awready;

    logic [ID_WIDTH-1:0]   wid;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;

    logic [ID_WIDTH-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
               awqos, awregion, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
               awqos, awregion, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/axi_burst_addr_gen.sv
// -----------------------------------------------------------------------------
// axi_burst_addr_gen
// Combinational AXI next-beat address calculation, shared by the write and
// read responders.
//   addr_i      current beat byte address
//   size_i      log2 bytes per beat
//   len_i       beats minus one
//   burst_i     FIXED / INCR / WRAP (RSVD holds the address)
//   next_addr_o address of the following beat
// -----------------------------------------------------------------------------
module axi_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = AXI_ADDR_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [2:0]            size_i,
    input  logic [7:0]            len_i,
    input  burst_e                burst_i,
    output logic [ADDR_WIDTH-1:0] next_addr_o
);

    localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [ADDR_WIDTH-1:0] step_s;
    logic [ADDR_WIDTH-1:0] span_s;
    logic [ADDR_WIDTH-1:0] mask_s;
    logic [ADDR_WIDTH-1:0] incr_s;

    // Next address: WRAP keeps the upper bits of the (len+1)<<size aligned
    // window and lets only the in-window offset roll over.
    always_comb begin
        step_s = ONE << size_i;
        span_s = ({{(ADDR_WIDTH-8){1'b0}}, len_i} + ONE) << size_i;
        mask_s = span_s - ONE;
        incr_s = addr_i + step_s;
        case (burst_i)
            BURST_FIXED: next_addr_o = addr_i;
            BURST_INCR:  next_addr_o = incr_s;
            BURST_WRAP:  next_addr_o = (addr_i & ~mask_s) | (incr_s & mask_s);
            default:     next_addr_o = addr_i;
        endcase
    end

endmodule

// File: rtl/axi_wr_responder.sv
// -----------------------------------------------------------------------------
// axi_wr_responder
// AXI write-side slave: accepts one burst at a time on AW/W, stores beats in
// an internal word-addressed memory and returns one B response per burst.
//   sig_clock  clock, rising edge
//   sig_reset  asynchronous active-high reset
//   bus        AXI write channels (slave modport of axi_wr_responder_if)
//   dbg_addr   debug word index
//   dbg_rdata  combinational memory read of word dbg_addr
// Optional build macro AXI_WR_WID_CHECK_EN: when defined, a beat whose wid
// differs from the latched awid is not written and flags SLVERR; when
// undefined wid is ignored.
// -----------------------------------------------------------------------------
module axi_wr_responder
    import axi_pkg::*;
#(
    parameter int                  ID_WIDTH   = AXI_ID_WIDTH,
    parameter int                  ADDR_WIDTH = AXI_ADDR_WIDTH,
    parameter int                  DATA_WIDTH = AXI_DATA_WIDTH,
    parameter int                  MEM_DEPTH  = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = {ADDR_WIDTH{1'b0}}
) (
    input  logic                         sig_clock,
    input  logic                         sig_reset,
    axi_wr_responder_if.slave            bus,
    input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0]        dbg_rdata
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int SIZE_SHIFT = $clog2(STRB_WIDTH);
    localparam int IDX_W      = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] SPAN =
        (ADDR_WIDTH+1)'(MEM_DEPTH * STRB_WIDTH);

    // Burst context and registered outputs.
    wr_state_e             state_q;
    logic                  awready_q;
    logic                  wready_q;
    logic                  bvalid_q;
    logic [ID_WIDTH-1:0]   bid_q;
    resp_e                 bresp_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [2:0]            size_q;
    burst_e                burst_q;
    logic [7:0]            cnt_q;
    resp_e                 err_q;
    logic                  setup_err_q;

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    // Beat decode.
    logic                  beat_s;
    logic [ADDR_WIDTH:0]   offset_s;
    logic                  in_range_s;
    logic [IDX_W-1:0]      word_idx_s;
    logic                  final_s;
    logic                  last_err_s;
    logic                  wid_ok_s;
    logic                  mem_we_s;
    logic                  end_s;
    resp_e                 err_d;
    logic                  setup_err_s;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic                  unused_s;

    axi_burst_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .addr_i      (addr_q),
        .size_i      (size_q),
        .len_i       (len_q),
        .burst_i     (burst_q),
        .next_addr_o (addr_d)
    );

`ifdef AXI_WR_WID_CHECK_EN
    assign wid_ok_s = (bus.wid == id_q);
    assign unused_s = ^{bus.awlock, bus.awcache, bus.awprot, bus.awqos,
                        bus.awregion};
`else
    assign wid_ok_s = 1'b1;
    assign unused_s = ^{bus.awlock, bus.awcache, bus.awprot, bus.awqos,
                        bus.awregion, bus.wid};
`endif

    // AW setup checks, evaluated on the raw AW fields at acceptance.
    always_comb begin
        setup_err_s = 1'b0;
        if (bus.awsize > 3'(SIZE_SHIFT)) begin
            setup_err_s = 1'b1;
        end else if (burst_e'(bus.awburst) == BURST_RSVD) begin
            setup_err_s = 1'b1;
        end else if ((burst_e'(bus.awburst) == BURST_WRAP) && !wrap_len_ok(bus.awlen)) begin
            setup_err_s = 1'b1;
        end else begin
            setup_err_s = 1'b0;
        end
    end

    // W beat decode: range check, word index, burst termination and the
    // error code the burst will carry after this beat.
    always_comb begin
        beat_s     = bus.wvalid && wready_q;
        offset_s   = {1'b0, addr_q} - {1'b0, BASE_ADDR};
        in_range_s = ({1'b0, addr_q} >= {1'b0, BASE_ADDR}) && (offset_s < SPAN);
        word_idx_s = offset_s[SIZE_SHIFT +: IDX_W];
        final_s    = (cnt_q == len_q);
        last_err_s = (bus.wlast != final_s);
        end_s      = final_s || bus.wlast;
        mem_we_s   = beat_s && in_range_s && !setup_err_q && wid_ok_s;
        err_d      = in_range_s ? err_q : RESP_DECERR;
        if (!wid_ok_s || last_err_s) begin
            err_d = resp_merge(err_d, RESP_SLVERR);
        end else begin
            err_d = err_d;
        end
    end

    // Responder FSM with registered handshake and response outputs.
    always_ff @(posedge sig_clock or posedge sig_reset) begin
        if (sig_reset) begin
            state_q     <= ST_IDLE;
            awready_q   <= 1'b1;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bid_q       <= {ID_WIDTH{1'b0}};
            bresp_q     <= RESP_OKAY;
            id_q        <= {ID_WIDTH{1'b0}};
            addr_q      <= {ADDR_WIDTH{1'b0}};
            len_q       <= 8'd0;
            size_q      <= 3'd0;
            burst_q     <= BURST_FIXED;
            cnt_q       <= 8'd0;
            err_q       <= RESP_OKAY;
            setup_err_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.awvalid && awready_q) begin
                        id_q        <= bus.awid;
                        addr_q      <= bus.awaddr;
                        len_q       <= bus.awlen;
                        size_q      <= bus.awsize;
                        burst_q     <= burst_e'(bus.awburst);
                        cnt_q       <= 8'd0;
                        setup_err_q <= setup_err_s;
                        err_q       <= setup_err_s ? RESP_SLVERR : RESP_OKAY;
                        awready_q   <= 1'b0;
                        wready_q    <= 1'b1;
                        state_q     <= ST_DATA;
                    end else begin
                        awready_q   <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (beat_s) begin
                        addr_q <= addr_d;
                        cnt_q  <= cnt_q + 8'd1;
                        err_q  <= err_d;
                        // A mismatched wlast ends the burst early or late;
                        // either way the response goes out next cycle.
                        if (end_s) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bid_q    <= id_q;
                            bresp_q  <= err_d;
                            state_q  <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (bvalid_q && bus.bready) begin
                        bvalid_q  <= 1'b0;
                        bid_q     <= {ID_WIDTH{1'b0}};
                        bresp_q   <= RESP_OKAY;
                        awready_q <= 1'b1;
                        state_q   <= ST_IDLE;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    awready_q <= 1'b1;
                    wready_q  <= 1'b0;
                    bvalid_q  <= 1'b0;
                end
            endcase
        end
    end

    // Byte-lane memory write; contents survive reset.
    always_ff @(posedge sig_clock) begin
        if (mem_we_s) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (bus.wstrb[i]) begin
                    mem_q[word_idx_s][8*i +: 8] <= bus.wdata[8*i +: 8];
                end
            end
        end
    end

    assign bus.awready = awready_q;
    assign bus.wready  = wready_q;
    assign bus.bvalid  = bvalid_q;
    assign bus.bid     = bid_q;
    assign bus.bresp   = bresp_q;
    assign dbg_rdata   = mem_q[dbg_addr];

endmodule

// File: tb/tb_axi_wr_responder.sv
// -----------------------------------------------------------------------------
// tb_axi_wr_responder
// Directed bench for axi_wr_responder: INCR, WRAP, strobes, decode errors,
// protocol errors, B backpressure and mid-burst reset.
// -----------------------------------------------------------------------------
module tb_axi_wr_responder;
    import axi_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  dbg_addr;
    logic [31:0] dbg_rdata;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    axi_wr_responder_if #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axi_wr_responder dut (
        .sig_clock (clk),
        .sig_reset (rst),
        .bus       (bus),
        .dbg_addr  (dbg_addr),
        .dbg_rdata (dbg_rdata)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_limit(input string tag, input int n);
        checks++;
        assert (n < 20) else begin
            errors++;
            $error("FAIL %s: waited %0d cycles, limit 20", tag, n);
        end
    endtask

    task automatic rd(input logic [7:0] idx, input logic [31:0] exp, input string tag);
        dbg_addr = idx;
        #1;
        check(tag, {32'h0, dbg_rdata}, {32'h0, exp});
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size;
        bus.awburst = burst; bus.awvalid = 1'b1;
        while (bus.awready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        wait_limit("aw_wait", n);
        @(negedge clk);
        bus.awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int n = 0;
        bus.wid = bus.awid; bus.wdata = data; bus.wstrb = strb; bus.wlast = last;
        bus.wvalid = 1'b1;
        while (bus.wready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        wait_limit("w_wait", n);
        @(negedge clk);
        bus.wvalid = 1'b0;
    endtask

    task automatic recv_b();
        int n = 0;
        bus.bready = 1'b1;
        while (bus.bvalid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        wait_limit("b_wait", n);
        @(negedge clk);
        bus.bready = 1'b0;
    endtask

    task automatic write1(input logic [31:0] addr, input logic [31:0] data);
        send_aw(4'h1, addr, 8'd0, 3'd2, 2'd1);
        send_w(data, 4'hF, 1'b1);
        recv_b();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.awid = 4'h0; bus.awaddr = 32'h0; bus.awlen = 8'd0; bus.awsize = 3'd0;
        bus.awburst = 2'd0; bus.awlock = 2'd0; bus.awcache = 4'd0; bus.awprot = 3'd0;
        bus.awqos = 4'd0; bus.awregion = 4'd0; bus.awvalid = 1'b0;
        bus.wid = 4'h0; bus.wdata = 32'h0; bus.wstrb = 4'h0; bus.wlast = 1'b0;
        bus.wvalid = 1'b0; bus.bready = 1'b0; dbg_addr = 8'd0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_awready", {63'h0, bus.awready}, 64'h1);
        check("rst_wready",  {63'h0, bus.wready},  64'h0);
        check("rst_bvalid",  {63'h0, bus.bvalid},  64'h0);
        check("rst_bid",     {60'h0, bus.bid},     64'h0);
        check("rst_bresp",   {62'h0, bus.bresp},   64'h0);
        rst = 1'b0;
        @(negedge clk);

        // Preloads: word 0, word 16, word 2
        write1(32'h0000_0000, 32'h1111_1111);
        write1(32'h0000_0040, 32'h2222_2222);
        write1(32'h0000_0008, 32'hFFFF_FFFF);
        rd(8'd0, 32'h1111_1111, "preload_w0");

        // INCR 4 beats at 0x10 -> words 4..7
        send_aw(4'h5, 32'h10, 8'd3, 3'd2, 2'd1);
        check("incr_wready_lat", {63'h0, bus.wready},  64'h1);
        check("incr_awready_lo", {63'h0, bus.awready}, 64'h0);
        send_w(32'hA0, 4'hF, 1'b0);
        send_w(32'hA1, 4'hF, 1'b0);
        send_w(32'hA2, 4'hF, 1'b0);
        send_w(32'hA3, 4'hF, 1'b1);
        check("incr_bvalid_lat", {63'h0, bus.bvalid}, 64'h1);
        check("incr_bid",        {60'h0, bus.bid},    64'h5);
        check("incr_bresp",      {62'h0, bus.bresp},  64'h0);
        recv_b();
        check("incr_awready_back", {63'h0, bus.awready}, 64'h1);
        rd(8'd4, 32'hA0, "incr_w4");
        rd(8'd5, 32'hA1, "incr_w5");
        rd(8'd6, 32'hA2, "incr_w6");
        rd(8'd7, 32'hA3, "incr_w7");

        // WRAP 4 beats at 0x38 -> 0x38, 0x3C, 0x30, 0x34
        send_aw(4'h3, 32'h38, 8'd3, 3'd2, 2'd2);
        send_w(32'hB0, 4'hF, 1'b0);
        send_w(32'hB1, 4'hF, 1'b0);
        send_w(32'hB2, 4'hF, 1'b0);
        send_w(32'hB3, 4'hF, 1'b1);
        check("wrap_bresp", {62'h0, bus.bresp}, 64'h0);
        check("wrap_bid",   {60'h0, bus.bid},   64'h3);
        recv_b();
        rd(8'd14, 32'hB0, "wrap_w14");
        rd(8'd15, 32'hB1, "wrap_w15");
        rd(8'd12, 32'hB2, "wrap_w12");
        rd(8'd13, 32'hB3, "wrap_w13");

        // Strobe: lanes 0 and 2 over 0xFFFFFFFF
        send_aw(4'h2, 32'h08, 8'd0, 3'd2, 2'd1);
        send_w(32'h1234_5678, 4'b0101, 1'b1);
        recv_b();
        rd(8'd2, 32'hFF34_FF78, "strobe_w2");

        // Out of range at 0x400: DECERR, word 0 untouched
        send_aw(4'h6, 32'h400, 8'd1, 3'd2, 2'd1);
        send_w(32'hDEAD_BEEF, 4'hF, 1'b0);
        send_w(32'hCAFE_F00D, 4'hF, 1'b1);
        check("oor_bresp", {62'h0, bus.bresp}, 64'h3);
        recv_b();
        rd(8'd0, 32'h1111_1111, "oor_w0");

        // Early wlast on beat 1 of 4
        send_aw(4'h7, 32'h80, 8'd3, 3'd2, 2'd1);
        send_w(32'h1, 4'hF, 1'b0);
        send_w(32'h2, 4'hF, 1'b1);
        check("early_bvalid", {63'h0, bus.bvalid}, 64'h1);
        check("early_wready", {63'h0, bus.wready}, 64'h0);
        check("early_bresp",  {62'h0, bus.bresp},  64'h2);
        recv_b();
        check("early_idle_awready", {63'h0, bus.awready}, 64'h1);

        // Final beat without wlast
        send_aw(4'h8, 32'h90, 8'd1, 3'd2, 2'd1);
        send_w(32'h3, 4'hF, 1'b0);
        send_w(32'h4, 4'hF, 1'b0);
        check("nolast_bresp", {62'h0, bus.bresp}, 64'h2);
        recv_b();

        // WRAP with illegal length: SLVERR, nothing written
        send_aw(4'h4, 32'h40, 8'd2, 3'd2, 2'd2);
        send_w(32'h3333_3333, 4'hF, 1'b0);
        send_w(32'h4444_4444, 4'hF, 1'b0);
        send_w(32'h5555_5555, 4'hF, 1'b1);
        check("wraplen_bresp", {62'h0, bus.bresp}, 64'h2);
        recv_b();
        rd(8'd16, 32'h2222_2222, "wraplen_w16");

        // Oversized beat: SLVERR, nothing written
        send_aw(4'h4, 32'h40, 8'd0, 3'd3, 2'd1);
        send_w(32'h6666_6666, 4'hF, 1'b1);
        check("size_bresp", {62'h0, bus.bresp}, 64'h2);
        recv_b();
        rd(8'd16, 32'h2222_2222, "size_w16");

        // B backpressure: five cycles with bready low
        send_aw(4'h9, 32'h20, 8'd0, 3'd2, 2'd1);
        send_w(32'h5A5A_5A5A, 4'hF, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("bp_bvalid",  {63'h0, bus.bvalid},  64'h1);
            check("bp_bid",     {60'h0, bus.bid},     64'h9);
            check("bp_bresp",   {62'h0, bus.bresp},   64'h0);
            check("bp_awready", {63'h0, bus.awready}, 64'h0);
            @(negedge clk);
        end
        recv_b();
        rd(8'd8, 32'h5A5A_5A5A, "bp_w8");

        // Reset mid-DATA: outputs drop immediately, written word survives
        send_aw(4'hA, 32'h60, 8'd3, 3'd2, 2'd1);
        send_w(32'h0000_0077, 4'hF, 1'b0);
        rst = 1'b1;
        #1;
        check("mid_rst_awready", {63'h0, bus.awready}, 64'h1);
        check("mid_rst_wready",  {63'h0, bus.wready},  64'h0);
        check("mid_rst_bvalid",  {63'h0, bus.bvalid},  64'h0);
        @(negedge clk);
        rst = 1'b0;
        rd(8'd24, 32'h0000_0077, "mid_rst_w24");
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
